idex_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection, placed directly downstream of the IF/ID register.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/idex_hazard_detect.sv | 37 +++
 rtl/idex_stage.sv | 117 +++++++++++
 tb/tb_idex_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared control-bundle layout and ALU opcodes for the MIPS datapath
// Purpose : single source of truth for the 14-bit control bundle, shared by
//           control_unit, idex_stage and the EX-stage logic.
// Contents: CTRL_W, bit indices of each control field, aluop codes,
//           ctrl_is_load() helper.
package mips_pkg;

   localparam int CTRL_W          = 14;

   // Bundle layout, MSB first:
   // {spare, reg_write, mem_read, mem_write, mem_to_reg, pc_to_reg, alusrc, branch, jump[1:0], aluop[3:0]}
   localparam int CTRL_SPARE      = 13;
   localparam int CTRL_REG_WRITE  = 12;
   localparam int CTRL_MEM_READ   = 11;
   localparam int CTRL_MEM_WRITE  = 10;
   localparam int CTRL_MEM_TO_REG = 9;
   localparam int CTRL_PC_TO_REG  = 8;
   localparam int CTRL_ALUSRC     = 7;
   localparam int CTRL_BRANCH     = 6;
   localparam int CTRL_JUMP_MSB   = 5;
   localparam int CTRL_JUMP_LSB   = 4;
   localparam int CTRL_ALUOP_MSB  = 3;
   localparam int CTRL_ALUOP_LSB  = 0;

   typedef enum logic [3:0] {
      ALU_AND = 4'h0,
      ALU_OR  = 4'h1,
      ALU_ADD = 4'h2,
      ALU_SUB = 4'h6,
      ALU_SLT = 4'h7,
      ALU_NOR = 4'hC
   } aluop_e;

   function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEM_READ];
   endfunction

endpackage

// File: rtl/idex_hazard_detect.sv
// rtl/idex_hazard_detect.sv - combinational load-use hazard and IF stall generation
// Purpose : flags when the instruction in ID needs a register that the load
//           currently in EX has not produced yet, and derives stall_if.
// Ports   : id_valid/id_rs/id_rt/id_uses_rt - ID instruction operands
//           ex_valid/ex_mem_read/ex_wa       - EX slot contents
//           flush, ext_stall                 - redirect / downstream busy
//           hz                               - load-use hazard
//           stall_if                         - hold PC and IF/ID this cycle
module idex_hazard_detect #(
   parameter int RA_W = 5
) (
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_uses_rt,
   input  logic            ex_valid,
   input  logic            ex_mem_read,
   input  logic [RA_W-1:0] ex_wa,
   input  logic            flush,
   input  logic            ext_stall,
   output logic            hz,
   output logic            stall_if
);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (ex_wa == id_rs);
   assign w_rt_match = id_uses_rt & (ex_wa == id_rt);

   // r0 is hardwired to zero, so a load targeting it creates no dependency.
   assign hz = id_valid & ex_valid & ex_mem_read & (ex_wa != '0) & (w_rs_match | w_rt_match);

   // A taken branch/jump must let the redirected PC load, so flush cancels the stall.
   assign stall_if = (hz | ext_stall) & ~flush;

endmodule

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with load-use bubble insertion
// Purpose : registers decoded controls and operands from ID for the EX stage,
//           inserts bubbles on flush and load-use hazards, holds on ext_stall,
//           and counts inserted load-use bubbles.
// Ports   : clk, reset (async active-low)
//           id_*      - decoded instruction from ID
//           flush     - kill the ID instruction
//           ext_stall - hold ID/EX contents
//           ex_*      - registered EX-stage view
//           stall_if  - combinational PC / IF/ID hold
//           bubble_cnt- saturating count of load-use bubbles
module idex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PC_W    = 8,
   parameter int RA_W    = 5,
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic              id_uses_rt,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [RA_W-1:0]   id_wa,
   input  logic [PC_W-1:0]   id_pc4,
   input  logic              flush,
   input  logic              ext_stall,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [RA_W-1:0]   ex_wa,
   output logic [PC_W-1:0]   ex_pc4,
   output logic              stall_if,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              r_ex_valid;
   logic [CTRL_W-1:0] r_ex_ctrl;
   logic [DATA_W-1:0] r_ex_rd1;
   logic [DATA_W-1:0] r_ex_rd2;
   logic [DATA_W-1:0] r_ex_imm;
   logic [RA_W-1:0]   r_ex_wa;
   logic [PC_W-1:0]   r_ex_pc4;
   logic [CNT_W-1:0]  r_bubble_cnt;
   logic              w_hz;

   idex_hazard_detect #(
      .RA_W (RA_W)
   ) u_hazard (
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_valid    (r_ex_valid),
      .ex_mem_read (ctrl_is_load(r_ex_ctrl)),
      .ex_wa       (r_ex_wa),
      .flush       (flush),
      .ext_stall   (ext_stall),
      .hz          (w_hz),
      .stall_if    (stall_if)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ex_valid   <= 1'b0;
         r_ex_ctrl    <= '0;
         r_ex_rd1     <= '0;
         r_ex_rd2     <= '0;
         r_ex_imm     <= '0;
         r_ex_wa      <= '0;
         r_ex_pc4     <= '0;
         r_bubble_cnt <= '0;
      end else if (flush || (!ext_stall && w_hz)) begin
         // Bubble: every control bit cleared so nothing is written downstream.
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= '0;
         r_ex_rd1   <= '0;
         r_ex_rd2   <= '0;
         r_ex_imm   <= '0;
         r_ex_wa    <= '0;
         r_ex_pc4   <= '0;
         // Only load-use bubbles are counted; flush bubbles are not.
         if (!flush && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
         end
      end else if (!ext_stall) begin
         r_ex_valid <= id_valid;
         r_ex_ctrl  <= id_valid ? id_ctrl : '0;
         r_ex_rd1   <= id_rd1;
         r_ex_rd2   <= id_rd2;
         r_ex_imm   <= id_imm;
         r_ex_wa    <= id_wa;
         r_ex_pc4   <= id_pc4;
      end
   end

   assign ex_valid   = r_ex_valid;
   assign ex_ctrl    = r_ex_ctrl;
   assign ex_rd1     = r_ex_rd1;
   assign ex_rd2     = r_ex_rd2;
   assign ex_imm     = r_ex_imm;
   assign ex_wa      = r_ex_wa;
   assign ex_pc4     = r_ex_pc4;
   assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - directed self-checking bench for idex_stage
module tb_idex_stage;

   localparam logic [13:0] C_ADDI = 14'h1082;  // reg_write, alusrc, aluop=ADD
   localparam logic [13:0] C_LW   = 14'h1A82;  // reg_write, mem_read, mem_to_reg, alusrc, ADD
   localparam logic [13:0] C_ADD  = 14'h1002;  // reg_write, aluop=ADD
   localparam logic [13:0] C_SW   = 14'h0482;  // mem_write, alusrc, ADD

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_wa;
   logic        id_uses_rt;
   logic [13:0] id_ctrl;
   logic [31:0] id_rd1, id_rd2, id_imm;
   logic [7:0]  id_pc4;
   logic        flush, ext_stall;

   logic        ex_valid, stall_if;
   logic [13:0] ex_ctrl;
   logic [31:0] ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_wa;
   logic [7:0]  ex_pc4;
   logic [15:0] bubble_cnt;

   logic        s_valid, s_stall_if;
   logic [13:0] s_ctrl;
   logic [31:0] s_rd1, s_rd2, s_imm;
   logic [4:0]  s_wa;
   logic [7:0]  s_pc4;
   logic [3:0]  s_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   idex_stage u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_wa(id_wa), .id_pc4(id_pc4), .flush(flush), .ext_stall(ext_stall),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_imm(ex_imm), .ex_wa(ex_wa), .ex_pc4(ex_pc4), .stall_if(stall_if),
      .bubble_cnt(bubble_cnt)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   idex_stage #(.CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_wa(id_wa), .id_pc4(id_pc4), .flush(flush), .ext_stall(ext_stall),
      .ex_valid(s_valid), .ex_ctrl(s_ctrl), .ex_rd1(s_rd1), .ex_rd2(s_rd2),
      .ex_imm(s_imm), .ex_wa(s_wa), .ex_pc4(s_pc4), .stall_if(s_stall_if),
      .bubble_cnt(s_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic [13:0] c, input logic [4:0] wa, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [7:0] pc4);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_ctrl = c;
      id_wa = wa; id_rd1 = rd1; id_rd2 = rd2; id_imm = rd1 ^ 32'h0000_FFFF; id_pc4 = pc4;
   endtask

   initial begin
      // T1: async reset with busy inputs, before any clock edge
      reset = 1'b0; flush = 1'b0; ext_stall = 1'b0;
      drive(1'b1, 5'd3, 5'd4, 1'b1, C_LW, 5'd7, 32'hDEAD_BEEF, 32'hCAFE_F00D, 8'h44);
      #2;
      check("rst_valid", ex_valid, 0);
      check("rst_ctrl", ex_ctrl, 0);
      check("rst_rd1", ex_rd1, 0);
      check("rst_rd2", ex_rd2, 0);
      check("rst_imm", ex_imm, 0);
      check("rst_wa", ex_wa, 0);
      check("rst_pc4", ex_pc4, 0);
      check("rst_cnt", bubble_cnt, 0);
      check("rst_stall", stall_if, 0);
      reset = 1'b1;

      // T2: addi passes straight through
      drive(1'b1, 5'd1, 5'd9, 1'b0, C_ADDI, 5'd9, 32'h1234_5678, 32'h0000_0BAD, 8'h04);
      #1 check("t2_stall_pre", stall_if, 0);
      step();
      check("t2_rd1", ex_rd1, 32'h1234_5678);
      check("t2_rd2", ex_rd2, 32'h0000_0BAD);
      check("t2_imm", ex_imm, 32'h1234_A987);
      check("t2_wa", ex_wa, 9);
      check("t2_pc4", ex_pc4, 8'h04);
      check("t2_valid", ex_valid, 1);
      check("t2_ctrl", ex_ctrl, C_ADDI);
      check("t2_stall", stall_if, 0);

      // T3: lw $8 followed by add $9,$8,$10
      drive(1'b1, 5'd2, 5'd8, 1'b0, C_LW, 5'd8, 32'h0000_0100, 32'h0, 8'h08);
      step();
      drive(1'b1, 5'd8, 5'd10, 1'b1, C_ADD, 5'd9, 32'h11, 32'h22, 8'h0C);
      #1 check("t3_stall", stall_if, 1);
      step();
      check("t3_bub_valid", ex_valid, 0);
      check("t3_bub_ctrl", ex_ctrl, 0);
      check("t3_bub_wa", ex_wa, 0);
      check("t3_cnt", bubble_cnt, 1);
      check("t3_stall_after", stall_if, 0);
      step();
      check("t3_add_valid", ex_valid, 1);
      check("t3_add_ctrl", ex_ctrl, C_ADD);
      check("t3_add_wa", ex_wa, 9);
      check("t3_add_rd1", ex_rd1, 32'h11);
      check("t3_cnt_hold", bubble_cnt, 1);

      // T4a: lw $0 then rs=0 user
      drive(1'b1, 5'd2, 5'd0, 1'b0, C_LW, 5'd0, 32'h0, 32'h0, 8'h10);
      step();
      drive(1'b1, 5'd0, 5'd3, 1'b1, C_ADD, 5'd4, 32'h33, 32'h44, 8'h14);
      #1 check("t4_r0_stall", stall_if, 0);
      step();
      check("t4_r0_wa", ex_wa, 4);
      check("t4_r0_cnt", bubble_cnt, 1);

      // T4b: lw $8 then addi with rt=8 not read
      drive(1'b1, 5'd2, 5'd8, 1'b0, C_LW, 5'd8, 32'h0, 32'h0, 8'h18);
      step();
      drive(1'b1, 5'd1, 5'd8, 1'b0, C_ADDI, 5'd8, 32'h55, 32'h66, 8'h1C);
      #1 check("t4_nort_stall", stall_if, 0);
      step();
      check("t4_nort_ctrl", ex_ctrl, C_ADDI);
      check("t4_nort_cnt", bubble_cnt, 1);

      // rt match with uses_rt=1 (sw) does stall; then T5 flush on top of it
      drive(1'b1, 5'd2, 5'd8, 1'b0, C_LW, 5'd8, 32'h0, 32'h0, 8'h20);
      step();
      drive(1'b1, 5'd1, 5'd8, 1'b1, C_SW, 5'd0, 32'h77, 32'h88, 8'h24);
      #1 check("t4_rt_stall", stall_if, 1);
      flush = 1'b1;
      #1 check("t5_flush_stall", stall_if, 0);
      step();
      check("t5_valid", ex_valid, 0);
      check("t5_ctrl", ex_ctrl, 0);
      check("t5_pc4", ex_pc4, 0);
      check("t5_cnt", bubble_cnt, 1);
      flush = 1'b0;

      // T6: ext_stall holds a valid addi for 3 edges
      drive(1'b1, 5'd1, 5'd2, 1'b0, C_ADDI, 5'd7, 32'h0000_AAAA, 32'h1, 8'h28);
      step();
      ext_stall = 1'b1;
      drive(1'b1, 5'd3, 5'd4, 1'b1, C_ADD, 5'd3, 32'h0000_5555, 32'h2, 8'h2C);
      #1 check("t6_stall_if", stall_if, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("t6_hold_rd1_%0d", i), ex_rd1, 32'h0000_AAAA);
         check($sformatf("t6_hold_wa_%0d", i), ex_wa, 7);
         check($sformatf("t6_hold_ctrl_%0d", i), ex_ctrl, C_ADDI);
         check($sformatf("t6_hold_valid_%0d", i), ex_valid, 1);
      end
      ext_stall = 1'b0;
      step();
      check("t6_release_rd1", ex_rd1, 32'h0000_5555);
      check("t6_release_wa", ex_wa, 3);

      // Invalid ID slot: ctrl must be forced to zero
      drive(1'b0, 5'd1, 5'd2, 1'b0, C_LW, 5'd5, 32'h99, 32'h0, 8'h30);
      step();
      check("inv_valid", ex_valid, 0);
      check("inv_ctrl", ex_ctrl, 0);

      // Reset asserted in the middle of a load-use stall
      drive(1'b1, 5'd2, 5'd8, 1'b0, C_LW, 5'd8, 32'h0, 32'h0, 8'h34);
      step();
      drive(1'b1, 5'd8, 5'd9, 1'b1, C_ADD, 5'd10, 32'hAB, 32'hCD, 8'h38);
      #1 check("mid_stall_pre", stall_if, 1);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", ex_valid, 0);
      check("mid_rst_ctrl", ex_ctrl, 0);
      check("mid_rst_cnt", bubble_cnt, 0);
      check("mid_rst_stall", stall_if, 0);
      reset = 1'b1;
      step();
      check("post_rst_valid", ex_valid, 1);
      check("post_rst_ctrl", ex_ctrl, C_ADD);
      check("post_rst_wa", ex_wa, 10);

      // Saturation: lw $8,0($8) held in ID hazards against itself every other edge
      drive(1'b1, 5'd8, 5'd0, 1'b0, C_LW, 5'd8, 32'h0, 32'h0, 8'h3C);
      step();
      for (int k = 1; k <= 15; k++) begin
         step();
         step();
      end
      check("sat_wide_15", bubble_cnt, 15);
      check("sat_narrow_15", s_cnt, 4'hF);
      check("sat_stall", stall_if, 1);
      step();
      check("sat_narrow_hold", s_cnt, 4'hF);
      check("sat_wide_16", bubble_cnt, 16);
      check("sat_bubble_ctrl", s_ctrl, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
